// File: rtl/dl_ctrl_pkg.sv
// dl_ctrl_pkg: opcodes, reply bytes and FSM state encoding shared by the delay-line command sequencer.
package dl_ctrl_pkg;
  localparam logic [7:0] OP_SET_TAP = 8'h01;
  localparam logic [7:0] OP_MEASURE = 8'h02;
  localparam logic [7:0] OP_READ_TAP = 8'h03;
  localparam logic [7:0] RSP_ACK = 8'h01;
  localparam logic [7:0] RSP_ERR = 8'hEE;
  localparam logic [15:0] RSP_TIMEOUT = 16'hFFFF;
  typedef enum logic [2:0] {S_IDLE, S_ARG, S_LAUNCH, S_WAIT, S_TX_HI, S_TX_LO} state_e;
endpackage

// File: rtl/dl_ctrl_wdog.sv
// dl_ctrl_wdog: measurement watchdog; counts enabled cycles since the last clear and flags TIMEOUT-1.
module dl_ctrl_wdog #(
  parameter int TIMEOUT = 4096
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_clr,
  input  logic i_en,
  output logic o_expired
);
  localparam int W = TIMEOUT > 1 ? $clog2(TIMEOUT) : 1;
  logic [W-1:0] cnt_q, cnt_d;
  always_comb cnt_d = i_clr ? '0 : i_en ? cnt_q + 1'b1 : cnt_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt_q <= '0;
    else cnt_q <= cnt_d;
  assign o_expired = cnt_q == W'(TIMEOUT - 1);
endmodule

// File: rtl/dl_ctrl.sv
// dl_ctrl: UART command sequencer for the delay line (SET_TAP / MEASURE / READ_TAP).
// Define DL_CTRL_AVG_EN to average 2**AVG_LOG2 measurements per MEASURE.
module dl_ctrl
  import dl_ctrl_pkg::*;
#(
  parameter int TAP_W = 8,
  parameter int CNT_W = 16,
  parameter int TIMEOUT = 4096,
  parameter int AVG_LOG2 = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_rx_valid,
  input  logic [7:0]       i_rx_data,
  output logic             o_tx_valid,
  output logic [7:0]       o_tx_data,
  input  logic             i_tx_ready,
  output logic [TAP_W-1:0] o_dl_tap,
  output logic             o_dl_launch,
  input  logic             i_dl_done,
  input  logic [CNT_W-1:0] i_dl_count,
  output logic             o_busy
);
  state_e state_q, state_d;
  logic [TAP_W-1:0] tap_q, tap_d;
  logic [15:0] res_q, res_d;
  logic expired, hs;
`ifdef DL_CTRL_AVG_EN
  logic [CNT_W+AVG_LOG2-1:0] acc_q, acc_d, acc_sum;
  logic [AVG_LOG2-1:0] smp_q, smp_d;
  assign acc_sum = acc_q + (CNT_W+AVG_LOG2)'(i_dl_count);
`endif
  assign hs = o_tx_valid && i_tx_ready;
  // The timer is zeroed on entry to LAUNCH so the launch cycle itself counts toward TIMEOUT.
  dl_ctrl_wdog #(.TIMEOUT(TIMEOUT)) u_wdog (
    .clk(clk),
    .rst_n(rst_n),
    .i_clr(state_d == S_LAUNCH),
    .i_en(state_q == S_LAUNCH || state_q == S_WAIT),
    .o_expired(expired)
  );
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state_q <= S_IDLE;
    else state_q <= state_d;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      tap_q <= '0;
      res_q <= '0;
`ifdef DL_CTRL_AVG_EN
      acc_q <= '0;
      smp_q <= '0;
`endif
    end else begin
      tap_q <= tap_d;
      res_q <= res_d;
`ifdef DL_CTRL_AVG_EN
      acc_q <= acc_d;
      smp_q <= smp_d;
`endif
    end
  always_comb begin
    state_d = state_q;
    tap_d = tap_q;
    res_d = res_q;
`ifdef DL_CTRL_AVG_EN
    acc_d = acc_q;
    smp_d = smp_q;
`endif
    case (state_q)
      S_IDLE: if (i_rx_valid) begin
        state_d = i_rx_data == OP_SET_TAP ? S_ARG : i_rx_data == OP_MEASURE ? S_LAUNCH : S_TX_LO;
        res_d = i_rx_data == OP_READ_TAP ? 16'(tap_q) : {8'h00, RSP_ERR};
`ifdef DL_CTRL_AVG_EN
        acc_d = '0;
        smp_d = '0;
`endif
      end
      S_ARG: if (i_rx_valid) begin
        tap_d = TAP_W'(i_rx_data);
        res_d = {8'h00, RSP_ACK};
        state_d = S_TX_LO;
      end
      S_LAUNCH: state_d = S_WAIT;
      S_WAIT: if (i_dl_done) begin
`ifdef DL_CTRL_AVG_EN
        acc_d = acc_sum;
        smp_d = smp_q + 1'b1;
        res_d = 16'(acc_sum >> AVG_LOG2);
        state_d = smp_q == '1 ? S_TX_HI : S_LAUNCH;
`else
        res_d = 16'(i_dl_count);
        state_d = S_TX_HI;
`endif
      end else if (expired) begin
        res_d = RSP_TIMEOUT;
        state_d = S_TX_HI;
      end
      S_TX_HI: state_d = hs ? S_TX_LO : S_TX_HI;
      S_TX_LO: state_d = hs ? S_IDLE : S_TX_LO;
      default: state_d = S_IDLE;
    endcase
  end
  always_comb begin
    o_busy = state_q != S_IDLE;
    o_dl_launch = state_q == S_LAUNCH;
    o_tx_valid = state_q == S_TX_HI || state_q == S_TX_LO;
    o_tx_data = state_q == S_TX_HI ? res_q[15:8] : state_q == S_TX_LO ? res_q[7:0] : 8'h00;
  end
  assign o_dl_tap = tap_q;
endmodule

// File: tb/tb_dl_ctrl.sv
// tb_dl_ctrl: directed vector table for single-byte commands plus hand-written measurement sequences.
module tb_dl_ctrl;
  localparam int TIMEOUT = 4096;
  localparam int NV = 12;
  typedef struct {
    logic [7:0] op;
    bit has_arg;
    logic [7:0] arg;
    logic [7:0] rsp;
    logic [7:0] tap;
  } vec_t;
  logic clk = 0;
  logic rst_n = 0;
  logic i_rx_valid = 0;
  logic [7:0] i_rx_data = 0;
  logic i_tx_ready = 0;
  logic i_dl_done = 0;
  logic [15:0] i_dl_count = 0;
  logic o_tx_valid, o_dl_launch, o_busy;
  logic [7:0] o_tx_data, o_dl_tap;
  int checks = 0;
  int errors = 0;
  vec_t vt[NV];
  dl_ctrl #(.TAP_W(8), .CNT_W(16), .TIMEOUT(TIMEOUT), .AVG_LOG2(2)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .i_rx_valid(i_rx_valid),
    .i_rx_data(i_rx_data),
    .o_tx_valid(o_tx_valid),
    .o_tx_data(o_tx_data),
    .i_tx_ready(i_tx_ready),
    .o_dl_tap(o_dl_tap),
    .o_dl_launch(o_dl_launch),
    .i_dl_done(i_dl_done),
    .i_dl_count(i_dl_count),
    .o_busy(o_busy)
  );
  always #5 clk = ~clk;
  initial begin
    #1_000_000;
    $display("FAIL global_timeout got=running want=finished");
    $fatal(1);
  end
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%0h want=%0h", name, act, exp);
    end
  endtask
  task automatic step();
    @(negedge clk);
  endtask
  task automatic send(input logic [7:0] b);
    i_rx_valid = 1;
    i_rx_data = b;
    @(negedge clk);
    i_rx_valid = 0;
    i_rx_data = 0;
  endtask
  task automatic get_byte(input string name, input logic [7:0] exp);
    int n = 0;
    while (!o_tx_valid && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk({name, "_valid"}, 32'(o_tx_valid), 1);
    chk(name, 32'(o_tx_data), 32'(exp));
    i_tx_ready = 1;
    @(negedge clk);
    i_tx_ready = 0;
  endtask
  task automatic chk_all_zero(input string name);
    chk({name, "_valid"}, 32'(o_tx_valid), 0);
    chk({name, "_data"}, 32'(o_tx_data), 0);
    chk({name, "_tap"}, 32'(o_dl_tap), 0);
    chk({name, "_launch"}, 32'(o_dl_launch), 0);
    chk({name, "_busy"}, 32'(o_busy), 0);
  endtask
  initial begin
    int n;
    bit ok;
    vt[0]  = '{8'h01, 1'b1, 8'h2A, 8'h01, 8'h2A};
    vt[1]  = '{8'h03, 1'b0, 8'h00, 8'h2A, 8'h2A};
    vt[2]  = '{8'h7F, 1'b0, 8'h00, 8'hEE, 8'h2A};
    vt[3]  = '{8'h00, 1'b0, 8'h00, 8'hEE, 8'h2A};
    vt[4]  = '{8'hFF, 1'b0, 8'h00, 8'hEE, 8'h2A};
    vt[5]  = '{8'h01, 1'b1, 8'h00, 8'h01, 8'h00};
    vt[6]  = '{8'h03, 1'b0, 8'h00, 8'h00, 8'h00};
    vt[7]  = '{8'h01, 1'b1, 8'hFF, 8'h01, 8'hFF};
    vt[8]  = '{8'h03, 1'b0, 8'h00, 8'hFF, 8'hFF};
    vt[9]  = '{8'h04, 1'b0, 8'h00, 8'hEE, 8'hFF};
    vt[10] = '{8'h01, 1'b1, 8'h5A, 8'h01, 8'h5A};
    vt[11] = '{8'h03, 1'b0, 8'h00, 8'h5A, 8'h5A};
    step();
    step();
    chk_all_zero("reset");
    rst_n = 1;
    step();
    i_dl_done = 1;
    i_dl_count = 16'h5555;
    step();
    i_dl_done = 0;
    step();
    chk("done_idle_busy", 32'(o_busy), 0);
    chk("done_idle_valid", 32'(o_tx_valid), 0);
    for (int i = 0; i < NV; i++) begin
      send(vt[i].op);
      if (vt[i].has_arg) begin
        chk($sformatf("vec%0d_arg_busy", i), 32'(o_busy), 1);
        chk($sformatf("vec%0d_arg_valid", i), 32'(o_tx_valid), 0);
        send(vt[i].arg);
        chk($sformatf("vec%0d_tap_now", i), 32'(o_dl_tap), 32'(vt[i].tap));
      end
      get_byte($sformatf("vec%0d_rsp", i), vt[i].rsp);
      chk($sformatf("vec%0d_idle", i), 32'(o_busy), 0);
      chk($sformatf("vec%0d_tap", i), 32'(o_dl_tap), 32'(vt[i].tap));
    end
`ifndef DL_CTRL_AVG_EN
    send(8'h02);
    chk("meas_launch", 32'(o_dl_launch), 1);
    n = 1;
    for (int i = 0; i < 99; i++) begin
      step();
      n += int'(o_dl_launch);
    end
    i_dl_done = 1;
    i_dl_count = 16'h1234;
    step();
    i_dl_done = 0;
    chk("meas_valid_latency", 32'(o_tx_valid), 1);
    get_byte("meas_hi", 8'h12);
    get_byte("meas_lo", 8'h34);
    chk("meas_launch_count", n, 1);
    chk("meas_idle", 32'(o_busy), 0);
    send(8'h02);
    for (int i = 0; i < TIMEOUT - 1; i++) step();
    chk("tie_no_valid", 32'(o_tx_valid), 0);
    i_dl_done = 1;
    i_dl_count = 16'h0ABC;
    step();
    i_dl_done = 0;
    get_byte("tie_hi", 8'h0A);
    get_byte("tie_lo", 8'hBC);
`else
    send(8'h02);
    for (int k = 0; k < 4; k++) begin
      n = 0;
      while (!o_dl_launch && n < 50) begin
        step();
        n++;
      end
      chk($sformatf("avg_launch%0d", k), 32'(o_dl_launch), 1);
      repeat (5) step();
      i_dl_done = 1;
      i_dl_count = 16'(10 + k);
      step();
      i_dl_done = 0;
    end
    chk("avg_no_extra_launch", 32'(o_dl_launch), 0);
    get_byte("avg_hi", 8'h00);
    get_byte("avg_lo", 8'h0B);
`endif
    send(8'h02);
    chk("to_launch", 32'(o_dl_launch), 1);
    n = 0;
    while (!o_tx_valid && n < TIMEOUT + 10) begin
      step();
      n++;
    end
    chk("to_latency", n, TIMEOUT);
    get_byte("to_hi", 8'hFF);
    chk("to_busy_mid", 32'(o_busy), 1);
    get_byte("to_lo", 8'hFF);
    chk("to_idle", 32'(o_busy), 0);
    send(8'h03);
    ok = 1;
    for (int i = 0; i < 50; i++) begin
      i_rx_valid = i == 10 || i == 11;
      i_rx_data = i == 10 ? 8'h01 : 8'h77;
      step();
      if (o_tx_valid !== 1'b1 || o_tx_data !== 8'h5A) ok = 0;
    end
    i_rx_valid = 0;
    i_rx_data = 0;
    chk("bp_stable", 32'(ok), 1);
    get_byte("bp_data", 8'h5A);
    chk("bp_idle", 32'(o_busy), 0);
    chk("bp_tap_kept", 32'(o_dl_tap), 32'h5A);
    ok = 0;
    repeat (10) begin
      step();
      if (o_tx_valid !== 1'b0) ok = 1;
    end
    chk("bp_no_extra_tx", 32'(ok), 0);
    send(8'h02);
    repeat (10) step();
    chk("rst_wait_busy", 32'(o_busy), 1);
    #2 rst_n = 0;
    #1 chk_all_zero("rst_async");
    @(negedge clk);
    rst_n = 1;
    ok = 0;
    for (int i = 0; i < 30; i++) begin
      i_dl_done = i == 5;
      i_dl_count = 16'h4321;
      step();
      if (o_tx_valid !== 1'b0 || o_busy !== 1'b0) ok = 1;
    end
    i_dl_done = 0;
    chk("rst_no_tx_after", 32'(ok), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
